// File: rtl/lpc_pkg.sv
// rtl/lpc_pkg.sv - shared LPC constants, Q-format, LFSR taps and filter FSM encoding
package lpc_pkg;
  localparam int ORDER     = 10;
  localparam int COEF_FRAC = 12;
  localparam int ACC_W     = 40;
  localparam int EXC_W     = 18;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // x^16 + x^14 + x^13 + x^11 + 1 seen from the shift-left register: bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXC  = 2'd1;
  localparam logic [1:0] ST_MAC  = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  localparam logic signed [ACC_W-1:0] SAT_MAX = 40'sd32767;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -40'sd32768;

  typedef struct packed {
    logic [15:0] gain;
    logic        voiced;
    logic [15:0] pitch_period;
  } frame_ctl_t;
endpackage

// File: rtl/lpc_excitation.sv
// rtl/lpc_excitation.sv - excitation source: pitch impulse train or scaled LFSR noise
module lpc_excitation
  import lpc_pkg::*;
(
  input  logic                    d_clk,
  input  logic                    rst,
  input  logic                    i_step,
  input  logic                    i_clear,
  input  logic                    i_voiced,
  input  logic [15:0]             i_pitch_period,
  input  logic [15:0]             i_gain,
  output logic signed [EXC_W-1:0] o_e
);
  logic [15:0]        r_cnt;
  logic [15:0]        r_lfsr;
  logic [15:0]        w_period;
  logic signed [32:0] w_noise_prod;

  assign w_period     = (i_pitch_period < 16'd2) ? 16'd2 : i_pitch_period;
  assign w_noise_prod = $signed(r_lfsr) * $signed({1'b0, i_gain});

  // Dropping the low 15 bits of a two's-complement product is a floor shift
  always_comb begin
    o_e = '0;
    if (i_voiced) begin
      if (r_cnt == 16'd0) o_e = $signed({2'b00, i_gain});
    end else begin
      o_e = w_noise_prod[32:15];
    end
  end

  always_ff @(posedge d_clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_lfsr <= LFSR_SEED;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_step) begin
      if (i_voiced) r_cnt <= (r_cnt == 16'd0) ? w_period - 16'd1 : r_cnt - 16'd1;
      else          r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
    end
  end
endmodule

// File: rtl/lpc_dec.sv
// rtl/lpc_dec.sv - LPC synthesis: excitation through a 10th-order all-pole filter, one shared MAC
module lpc_dec
  import lpc_pkg::*;
(
  input  logic        d_clk,
  input  logic        rst,
  input  logic [15:0] A1,
  input  logic [15:0] A2,
  input  logic [15:0] A3,
  input  logic [15:0] A4,
  input  logic [15:0] A5,
  input  logic [15:0] A6,
  input  logic [15:0] A7,
  input  logic [15:0] A8,
  input  logic [15:0] A9,
  input  logic [15:0] A10,
  input  logic [15:0] gain,
  input  logic        voiced,
  input  logic [15:0] pitch_period,
  input  logic        load,
  input  logic        v,
  output logic [15:0] y,
  output logic        vout,
  output logic        busy,
  output logic        overrun
);
  logic signed [15:0]       w_a_in [ORDER];
  logic signed [15:0]       w_stg_a [ORDER];
  logic signed [15:0]       r_stg_a [ORDER];
  logic signed [15:0]       r_a [ORDER];
  logic signed [15:0]       r_hist [ORDER];
  frame_ctl_t               w_ctl_in, w_stg_ctl, r_stg_ctl, r_ctl;
  logic                     r_pend, w_pend, w_apply, w_step;
  logic [1:0]               r_state;
  logic [3:0]               r_k;
  logic signed [ACC_W-1:0]  r_acc, w_acc_next, w_shift;
  logic signed [31:0]       w_prod;
  logic signed [EXC_W-1:0]  w_e;
  logic signed [15:0]       w_y_sat, r_y;
  logic                     r_vout, r_overrun;

  assign w_a_in   = '{A1, A2, A3, A4, A5, A6, A7, A8, A9, A10};
  assign w_ctl_in = {gain, voiced, pitch_period};

  // A load in the same cycle as the apply point wins over older staged values
  always_comb begin
    w_stg_a   = r_stg_a;
    w_stg_ctl = r_stg_ctl;
    if (load) begin
      w_stg_a   = w_a_in;
      w_stg_ctl = w_ctl_in;
    end
  end

  assign w_pend  = load | r_pend;
  assign w_apply = (r_state == ST_IDLE) && w_pend;
  assign w_step  = (r_state == ST_EXC);

  lpc_excitation u_exc (
    .d_clk          (d_clk),
    .rst            (rst),
    .i_step         (w_step),
    .i_clear        (w_apply),
    .i_voiced       (r_ctl.voiced),
    .i_pitch_period (r_ctl.pitch_period),
    .i_gain         (r_ctl.gain),
    .o_e            (w_e)
  );

  assign w_prod     = r_a[r_k] * r_hist[r_k];
  assign w_acc_next = r_acc - {{(ACC_W-32){w_prod[31]}}, w_prod};
  assign w_shift    = w_acc_next >>> COEF_FRAC;

  always_comb begin
    w_y_sat = w_shift[15:0];
    if (w_shift > SAT_MAX)      w_y_sat = 16'sh7FFF;
    else if (w_shift < SAT_MIN) w_y_sat = 16'sh8000;
  end

  // The last tap is folded into OUT so v can be accepted in the cycle vout is high
  always_ff @(posedge d_clk) begin
    if (rst) begin
      r_stg_a   <= '{default: '0};
      r_a       <= '{default: '0};
      r_hist    <= '{default: '0};
      r_stg_ctl <= '0;
      r_ctl     <= '0;
      r_pend    <= 1'b0;
      r_state   <= ST_IDLE;
      r_k       <= '0;
      r_acc     <= '0;
      r_y       <= '0;
      r_vout    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_vout <= 1'b0;
      if (load) begin
        r_stg_a   <= w_a_in;
        r_stg_ctl <= w_ctl_in;
      end
      r_pend <= w_pend & ~w_apply;
      if (w_apply) begin
        r_a   <= w_stg_a;
        r_ctl <= w_stg_ctl;
      end
      if (v && r_state != ST_IDLE) r_overrun <= 1'b1;
      case (r_state)
        ST_IDLE: if (v) r_state <= ST_EXC;
        ST_EXC: begin
          r_acc   <= {{(ACC_W-EXC_W){w_e[EXC_W-1]}}, w_e} << COEF_FRAC;
          r_k     <= '0;
          r_state <= ST_MAC;
        end
        ST_MAC: begin
          r_acc <= w_acc_next;
          r_k   <= r_k + 4'd1;
          if (r_k == 4'(ORDER - 2)) r_state <= ST_OUT;
        end
        default: begin
          r_y       <= w_y_sat;
          r_hist[0] <= w_y_sat;
          for (int i = 1; i < ORDER; i++) r_hist[i] <= r_hist[i-1];
          r_vout    <= 1'b1;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign y       = r_y;
  assign vout    = r_vout;
  assign busy    = (r_state != ST_IDLE);
  assign overrun = r_overrun;
endmodule

// File: doc/lpc_dec.md
Name: lpc_dec

Overview:
LPC synthesis (decode) block and counterpart of the LPC analysis encoder. It takes one frame of predictor coefficients A1..A10, a voiced flag, a pitch period and a gain. For each sample strobe it builds an excitation sample (impulse train if voiced, LFSR noise if unvoiced) and passes it through a 10th-order all-pole filter. One time-shared MAC serves the filter, and the block drives the audio DAC path on the d_clk sample domain.

Parameters:
ORDER, 10, predictor order (A1..A_ORDER; A0 is implicit 1.0 and not an input)
COEF_FRAC, 12, fractional bits of coefficients (Q3.12, 1.0 = 4096)
ACC_W, 40, accumulator width
LFSR_SEED, 16'hACE1, noise generator reset value

Ports:
d_clk  in  1  clock; all logic is in this domain
rst  in  1  reset
A1..A10  in  16 each  signed Q3.12 predictor coefficients
gain  in  16  unsigned excitation amplitude
voiced  in  1  1 = impulse excitation, 0 = noise
pitch_period  in  16  samples between impulses
load  in  1  one-cycle strobe that latches A1..A10, gain, voiced, pitch_period
v  in  1  one-cycle strobe requesting one output sample
y  out  16  signed synthesized sample
vout  out  1  one-cycle strobe; y is valid
busy  out  1  sample computation in progress
overrun  out  1  sticky; v arrived while busy

Behaviour:
- Reset: reset rst, synchronous, active-high; clock d_clk. y=0, vout=0, busy=0, overrun=0, history y[n-1..n-10]=0, shadow coefficients/gain=0, voiced=0, pitch counter=0, LFSR=LFSR_SEED, state=IDLE, pending-load flag clear.
- Frame load: on load, latch inputs into a staging register and set load_pending. Staging is copied to the working registers only in IDLE, either on the cycle v is accepted or when IDLE with load_pending. A load during a computation never alters the sample in flight. A second load before application overwrites staging. Applying a load clears the pitch counter to 0.
- FSM: IDLE -> EXC on v. EXC (1 cycle) -> MAC (ORDER cycles, k=1..10) -> OUT (1 cycle) -> IDLE.
- IDLE: busy=0. When v is accepted, apply any pending load first, then go to EXC.
- EXC: compute the excitation e.
  - Voiced: if cnt==0, e=gain (zero-extended) and cnt<=max(pitch_period,2)-1; otherwise e=0 and cnt<=cnt-1.
  - Unvoiced: e=(signed(lfsr)*gain)>>>15 using arithmetic shift (floor). The LFSR then advances one step: Fibonacci, taps x^16+x^14+x^13+x^11+1, shift left, feedback into bit 0.
  - acc <= e<<<COEF_FRAC, sign-extended to ACC_W.
- MAC cycle k: acc <= acc - A_k*y[n-k]. Each product is a full 32-bit signed product.
- OUT: y <= saturate(acc>>>COEF_FRAC) to [-32768, 32767]. Shift history (y[n-1] <= y), vout=1 for this cycle only.
- Latency: v at cycle t gives vout at t+12. Minimum v spacing is 12 cycles; back-to-back throughput is one sample per 12 cycles (v may be re-accepted in the cycle after OUT).
- v while busy (EXC/MAC/OUT): ignored, sample not generated, overrun<=1. overrun is cleared only by rst.
- Simultaneous load and v in IDLE: the new load is applied to that same sample.
- rst mid-computation: abort, no vout, all state returns to reset values.
- pitch_period 0 or 1: treated as 2.
- y holds its value between vout strobes.

Decomposition:
- Shared package lpc_pkg: ORDER, COEF_FRAC, ACC_W, LFSR_SEED, LFSR tap mask, FSM state encoding (IDLE, EXC, MAC, OUT), saturation limits. The encoder and the decoder share the coefficient Q-format constant.
- One sub-module, lpc_excitation: pitch counter, LFSR and the voiced/unvoiced mux. Inputs are step strobe, voiced, pitch_period, gain and clear; output is e. The filter FSM, MAC, history and saturation stay in lpc_dec.

Test Plan:
1. Impulse train: A=0, voiced=1, pitch_period=4, gain=1000, load, then v every 12 cycles -> y=1000,0,0,0,1000,0,0,0,...; each vout exactly 12 cycles after its v.
2. One-pole decay: A1=2048 (+0.5, so y=e-0.5*y[n-1]), rest 0, voiced=1, pitch=100, gain=4096 -> y=4096,-2048,1024,-512,256.
3. Saturation: A1=-8192 (-2.0), pitch=100, gain=1000 -> y=1000,2000,4000,8000,16000,32000,32767,32767.
4. Noise: voiced=0, gain=32767, A=0 after reset -> first y=-21279 (0xACE1*32767>>>15); the second sample uses the advanced LFSR value, and the sequence matches the reference model for 64 samples.
5. Overrun: v, then v again 5 cycles later -> only one vout, overrun=1 and stays 1 until rst.
6. Mid-operation events: load of new A1 at MAC cycle 3 -> current sample uses old coefficients and the next sample uses new ones with pitch counter restarted. rst asserted at MAC cycle 6 -> no vout, y=0, history cleared, LFSR=0xACE1.
